// File: rtl/pwm_multi_gen_pkg.sv
// pwm_pkg: shared constants, register-select type and address decode helper
// for the multi-channel PWM generator. Optional feature macro: PWM_POL_EN.
package pwm_pkg;

  localparam int PWM_S_DEFAULT  = 11;
  localparam int PWM_CH_DEFAULT = 4;
  localparam int ADDR_PERIOD    = 0;
  localparam int ADDR_CMP_BASE  = 1;

  // Which shadow register class a write address targets
  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_PERIOD = 2'd1,
    SEL_CMP    = 2'd2,
    SEL_POL    = 2'd3
  } reg_sel_e;

  // Polarity mask sits directly after the last compare register
  function automatic int addr_pol(input int ch);
    return ch + 1;
  endfunction

  // Classify a register address; anything past the last defined one is ignored
  function automatic reg_sel_e decode_addr(input int a, input int ch, input bit pol_en);
    reg_sel_e sel;
    if (a == ADDR_PERIOD) begin
      sel = SEL_PERIOD;
    end else if ((a >= ADDR_CMP_BASE) && (a < ADDR_CMP_BASE + ch)) begin
      sel = SEL_CMP;
    end else if (pol_en && (a == addr_pol(ch))) begin
      sel = SEL_POL;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pwm_multi_gen_if.sv
// pwm_multi_gen_if: shadow-register write port (strobe, address, data).
interface pwm_multi_gen_if #(
  parameter int AW = 3,
  parameter int s  = 11
);
  logic          wr;
  logic [AW-1:0] addr;
  logic [s-1:0]  wdata;

  modport master (output wr, addr, wdata);
  modport slave  (input  wr, addr, wdata);
endinterface

// File: rtl/pwm_multi_gen_chan.sv
// pwm_chan: one PWM channel -- compare shadow/active pair and registered
// pulse output. With PWM_POL_EN defined it also carries a polarity bit.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int s = PWM_S_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         load,      // ce & period boundary
  input  logic         n_sh_nz,   // period shadow is non-zero
  input  logic [s-1:0] q,
  input  logic         wr_sel,
  input  logic [s-1:0] wdata,
`ifdef PWM_POL_EN
  input  logic         pol_wr_sel,
  input  logic         pol_wdata,
`endif
  output logic         pw,
  output logic         end_pw
);

  logic [s-1:0] cmp_sh_q, cmp_sh_d;
  logic [s-1:0] cmp_act_q, cmp_act_d;
  logic         pw_raw_d;
  logic         pw_raw_q;
  logic         pw_q;
  logic         pol_act_d;

`ifdef PWM_POL_EN
  logic pol_sh_q, pol_sh_d, pol_act_q;

  // Polarity shadow write and boundary transfer
  always_comb begin
    if (pol_wr_sel) begin
      pol_sh_d = pol_wdata;
    end else begin
      pol_sh_d = pol_sh_q;
    end
    if (load) begin
      pol_act_d = pol_sh_q;
    end else begin
      pol_act_d = pol_act_q;
    end
  end

  // Polarity state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_sh_q  <= 1'b0;
      pol_act_q <= 1'b0;
    end else begin
      pol_sh_q  <= pol_sh_d;
      pol_act_q <= pol_act_d;
    end
  end
`else
  assign pol_act_d = 1'b0;
`endif

  // Compare shadow write, boundary load and pulse start/end rules
  always_comb begin
    cmp_act_d = cmp_act_q;
    pw_raw_d  = pw_raw_q;
    if (wr_sel) begin
      cmp_sh_d = wdata;
    end else begin
      cmp_sh_d = cmp_sh_q;
    end
    if (load) begin
      // start has priority over end; the load sees pre-edge shadow values
      cmp_act_d = cmp_sh_q;
      pw_raw_d  = (cmp_sh_q != {s{1'b0}}) && n_sh_nz;
    end else if (ce && (q == cmp_act_q)) begin
      pw_raw_d  = 1'b0;
    end else begin
      pw_raw_d  = pw_raw_q;
    end
  end

  // Channel state registers; polarity folded in so the output adds no latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_sh_q  <= {s{1'b0}};
      cmp_act_q <= {s{1'b0}};
      pw_raw_q  <= 1'b0;
      pw_q      <= 1'b0;
    end else begin
      cmp_sh_q  <= cmp_sh_d;
      cmp_act_q <= cmp_act_d;
      pw_raw_q  <= pw_raw_d;
      pw_q      <= pw_raw_d ^ pol_act_d;
    end
  end

  assign pw     = pw_q;
  assign end_pw = (q == cmp_act_q) && (cmp_act_q != {s{1'b0}});

endmodule

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: shared period counter driving CH pulse channels, with
// shadow registers that transfer to active values only at the period boundary.
// Optional polarity mask at address CH+1 when PWM_POL_EN is defined.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int s  = PWM_S_DEFAULT,
  parameter int CH = PWM_CH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  pwm_multi_gen_if.slave bus,
  output logic [CH-1:0] pw,
  output logic          start_pw,
  output logic [CH-1:0] end_pw,
  output logic [s-1:0]  q
);

  localparam int AW = $clog2(CH + 2);
`ifdef PWM_POL_EN
  localparam bit POL_EN = 1'b1;
`else
  localparam bit POL_EN = 1'b0;
`endif
  localparam logic [s-1:0] ONE = {{(s-1){1'b0}}, 1'b1};

  logic [s-1:0]  cnt_q, cnt_d;
  logic [s-1:0]  n_sh_q, n_sh_d;
  logic [s-1:0]  n_act_q, n_act_d;
  logic          load_s;
  reg_sel_e      sel_s;
  logic [CH-1:0] cmp_wr_s;

  assign sel_s    = decode_addr(int'(bus.addr), CH, POL_EN);
  assign start_pw = (cnt_q == n_act_q);
  assign load_s   = ce && start_pw;
  assign q        = cnt_q;

  // Per-channel compare write strobes
  always_comb begin
    cmp_wr_s = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      if (bus.wr && (sel_s == SEL_CMP) && (bus.addr == AW'(ADDR_CMP_BASE + i))) begin
        cmp_wr_s[i] = 1'b1;
      end else begin
        cmp_wr_s[i] = 1'b0;
      end
    end
  end

  // Period shadow write, boundary load and counter advance
  always_comb begin
    n_act_d = n_act_q;
    cnt_d   = cnt_q;
    if (bus.wr && (sel_s == SEL_PERIOD)) begin
      n_sh_d = bus.wdata;
    end else begin
      n_sh_d = n_sh_q;
    end
    if (load_s) begin
      // an empty period keeps the counter parked at 0 (idle)
      n_act_d = n_sh_q;
      cnt_d   = (n_sh_q == {s{1'b0}}) ? {s{1'b0}} : ONE;
    end else if (ce) begin
      cnt_d   = cnt_q + ONE;
    end else begin
      cnt_d   = cnt_q;
    end
  end

  // Counter and period registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= {s{1'b0}};
      n_sh_q  <= {s{1'b0}};
      n_act_q <= {s{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      n_sh_q  <= n_sh_d;
      n_act_q <= n_act_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
`ifdef PWM_POL_EN
    logic pol_wr_s;
    assign pol_wr_s = bus.wr && (sel_s == SEL_POL);
`endif
    pwm_chan #(.s(s)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .load       (load_s),
      .n_sh_nz    (n_sh_q != {s{1'b0}}),
      .q          (cnt_q),
      .wr_sel     (cmp_wr_s[g]),
      .wdata      (bus.wdata),
`ifdef PWM_POL_EN
      .pol_wr_sel (pol_wr_s),
      .pol_wdata  (bus.wdata[g]),
`endif
      .pw         (pw[g]),
      .end_pw     (end_pw[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: directed scoreboard bench for pwm_multi_gen (N=10 periods,
// shadow timing, ce freeze, idle, async reset). Honours PWM_POL_EN if defined.
module tb_pwm_multi_gen;

`ifdef PWM_POL_EN
  localparam logic [3:0] POL = 4'b0101;
`else
  localparam logic [3:0] POL = 4'b0000;
`endif

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [3:0]  pw;
  logic        start_pw;
  logic [3:0]  end_pw;
  logic [10:0] q;

  pwm_multi_gen_if #(.AW(3), .s(11)) bus_if ();

  pwm_multi_gen #(.s(11), .CH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .bus      (bus_if),
    .pw       (pw),
    .start_pw (start_pw),
    .end_pw   (end_pw),
    .q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [10:0] q;
    logic [3:0]  pw;
    logic        st;
    logic [3:0]  ep;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] pol_exp = 4'b0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int eq, input logic [3:0] epw,
                          input logic est, input logic [3:0] eep);
    exp_t e;
    e.tag = tag; e.q = eq[10:0]; e.pw = epw ^ pol_exp; e.st = est; e.ep = eep;
    sb_q.push_back(e);
  endtask

  task automatic push_idle(input string tag);
    push_exp(tag, 0, 4'b0000, 1'b1, 4'b0000);
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_q"},        32'(q),        32'(e.q));
      chk({e.tag, "_pw"},       32'(pw),       32'(e.pw));
      chk({e.tag, "_start_pw"}, 32'(start_pw), 32'(e.st));
      chk({e.tag, "_end_pw"},   32'(end_pw),   32'(e.ep));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [10:0] d);
    bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    push_idle("idle_wr");
    tick();
    bus_if.wr = 1'b0;
    check_pop();
  endtask

  // One N=10 period: ch0 high for q=1..width, ch2/ch3 constantly high if full.
  task automatic run_period(input int width, input bit full, input int wr_at,
                            input logic [2:0] wa, input logic [10:0] wd, input int frz_at);
    int hi = 0;
    logic [3:0] epw;
    logic [3:0] eep;
    for (int k = 1; k <= 10; k++) begin
      epw = {full, full, 1'b0, (k <= width)};
      eep = {1'b0, (full && (k == 10)), 1'b0, (k == width)};
      push_exp("period", k, epw, (k == 10), eep);
      tick();
      bus_if.wr = 1'b0;
      check_pop();
      if (pw[0]) hi++;
      if (k == wr_at) begin
        bus_if.wr = 1'b1; bus_if.addr = wa; bus_if.wdata = wd;
      end
      if (k == frz_at) begin
        ce = 1'b0;
        for (int f = 0; f < 5; f++) begin
          push_exp("freeze", k, epw, (k == 10), eep);
          tick();
          check_pop();
        end
        ce = 1'b1;
      end
    end
    chk("high_cycles", 32'(hi), 32'(width));
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0;
    bus_if.wr = 1'b0; bus_if.addr = 3'd0; bus_if.wdata = 11'd0;
    #2;
    push_idle("reset");
    check_pop();
    #10;
    rst_n = 1'b1;
    ce = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_idle("idle_after_reset");
      tick();
      check_pop();
    end

    // compare values first, period last so generation starts cleanly
    wr_reg(3'd1, 11'd3);
    wr_reg(3'd2, 11'd0);
    wr_reg(3'd3, 11'd10);
    wr_reg(3'd4, 11'd15);
    wr_reg(3'd0, 11'd10);

    run_period(3, 1'b1, 0,  3'd0, 11'd0, 0);   // first period after load
    run_period(3, 1'b1, 5,  3'd1, 11'd7, 0);   // mid-period write 3->7
    run_period(7, 1'b1, 10, 3'd1, 11'd3, 0);   // write 7->3 on boundary cycle
    run_period(7, 1'b1, 0,  3'd0, 11'd0, 0);   // boundary write not yet visible
    run_period(3, 1'b1, 0,  3'd0, 11'd0, 2);   // ce frozen 5 cycles at q=2
    run_period(3, 1'b1, 4,  3'd0, 11'd0, 0);   // N=0 written mid-period

    for (int i = 0; i < 3; i++) begin
      push_idle("idle_n0");
      tick();
      check_pop();
    end

    // polarity mask (ignored without the optional feature)
    wr_reg(3'd5, {7'd0, 4'b0101});
    pol_exp = POL;
    push_idle("idle_pol");
    tick();
    check_pop();

    // out-of-range address must not touch the period shadow
    wr_reg(3'd7, 11'd5);
    for (int i = 0; i < 2; i++) begin
      push_idle("idle_bad_addr");
      tick();
      check_pop();
    end

    // restart, then async reset mid-pulse
    wr_reg(3'd0, 11'd10);
    for (int k = 1; k <= 2; k++) begin
      push_exp("pre_reset", k, 4'b1101, 1'b0, 4'b0000);
      tick();
      check_pop();
    end
    #3;
    rst_n = 1'b0;
    pol_exp = 4'b0000;
    #1;
    push_idle("async_reset");
    check_pop();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_idle("idle_post_reset");
      tick();
      check_pop();
    end

    // shadows were cleared: only ch0 reprogrammed
    wr_reg(3'd1, 11'd5);
    wr_reg(3'd0, 11'd10);
    run_period(5, 1'b0, 0, 3'd0, 11'd0, 0);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
Multi-channel pulse-width generator. One shared period counter drives CH channels, each with its own compare (pulse-end) value. The period and compare values are written through a simple register port into shadow registers. Shadows transfer to the active registers only at a period boundary, so pulse updates are glitch-free. It sits in the timing/pulse generation layer and is clocked with a clock-enable from the prescaler.

Parameters:
- s, 11, counter/period/compare width in bits
- CH, 4, number of PWM channels (1..16)
- AW, $clog2(CH+2), register address width (localparam, derived)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- ce  in  1  count enable; when low, counter, pw and active registers freeze
- wr  in  1  shadow register write strobe (not gated by ce)
- addr  in  AW  register address: 0 = period N; 1..CH = compare of channel addr-1; CH+1 = polarity mask (optional feature)
- wdata  in  s  write data
- pw  out  CH  pulse outputs, registered
- start_pw  out  1  combinational, q == N_act (period boundary)
- end_pw  out  CH  combinational, end_pw[i] = (q == cmp_act[i]) & (cmp_act[i] != 0)
- q  out  s  period counter

Behaviour:
- Reset (rst_n low, async): q=0, pw=0, N_act=0, N_sh=0, all cmp_act=0, all cmp_sh=0.
- Writes: on a clk edge with wr=1, wdata goes to the shadow selected by addr. Addresses above the last defined one are ignored. Writes are accepted regardless of ce.
- Load cycle = ce & start_pw:
  - N_act <= N_sh and cmp_act[i] <= cmp_sh[i].
  - The load uses shadow values from before the edge. A write in the same cycle takes effect at the next boundary.
  - q <= (N_sh == 0) ? 0 : 1.
  - pw[i] <= (cmp_sh[i] != 0) & (N_sh != 0).
- Other ce cycles:
  - q <= q+1.
  - pw[i] <= 0 if q == cmp_act[i], else hold.
  - In a load cycle the start rule has priority over end.
- Resulting waveform for 0 < cmp < N: pw high for q = 1..cmp, i.e. exactly cmp cycles out of an N-cycle period.
- Boundary cases:
  - cmp >= N: pw high for the whole period (100%).
  - cmp = 0: pw constantly 0.
- Idle: N_act = 0 means q stays 0 and start_pw=1 on every ce cycle, so shadows reload continuously. Writing N != 0 starts generation on the next ce cycle.
- After reset the block is idle until N_sh != 0. First pw rise is 1 ce cycle after the load.
- q never exceeds N_act, so there is no wrap-around. N_act = 2^s-1 is legal.
- ce=0: all state except shadows holds; outputs are stable.
- Reset mid-period: immediately forces every output to its reset value. The block restarts from idle; pre-reset shadow contents are lost.

Optional Feature:
- Macro: PWM_POL_EN.
- Defined:
  - Adds a CH-bit polarity shadow at addr CH+1 (wdata[CH-1:0]) and a matching active register, loaded at the boundary like the others.
  - Output pw[i] = pw_raw[i] ^ pol_act[i], registered so there is no extra latency. Reset value of pol is 0.
  - An inverted channel idles high while N_act = 0.
- Undefined: addr CH+1 is ignored and pw = pw_raw.

Decomposition:
- Package pwm_pkg: address constants ADDR_PERIOD=0, ADDR_CMP_BASE=1, ADDR_POL(CH)=CH+1, and the default width constant.
- Sub-module pwm_chan (one per channel, generate loop):
  - holds cmp_sh, cmp_act, the pw flop and the optional polarity bit;
  - inputs: load, q, ce, write select, wdata.
- The top holds q, N_sh/N_act and address decode.

Test Plan:
- Reset, write N=10, cmp ch0=3, hold ce=1 → start_pw every 10 cycles; pw[0] high exactly 3 cycles per period; q sequence 1..10.
- cmp ch1=0, cmp ch2=10, cmp ch3=15 with N=10 → pw[1] constantly 0; pw[2] and pw[3] constantly 1 after first load.
- Change ch0 cmp 3→7 at q=5, and again exactly at the q==N cycle → current period keeps width 3; width 7 appears one period later in the boundary-write case.
- Toggle ce low for 5 cycles at q=2 with pw high → q, pw frozen for 5 cycles; total high time remains 3 ce-cycles.
- Assert rst_n low mid-pulse (asynchronous to clk) → pw=0 and q=0 before the next edge; after release, no pulses until N is rewritten.
- Write N=0 mid-period → current period completes; then q held at 0 and pw all 0. With PWM_POL_EN and mask 4'b0101 → pw[0] and pw[2] inverted, idle high.
